iter_alu: RTL and testbench

- Parametrised, handshaked successor to the single-cycle MIPS ALU.
- Keeps the existing 4-bit operation encoding, generalised to WIDTH bits.
- Adds iterative unsigned multiply and divide, which produce a HI/LO pair.
- Sits between decode/register-read and writeback; the pipeline stalls on in_ready/out_valid.

---
 rtl/iter_alu_if.sv | 26 ++
 rtl/iter_alu.sv | 196 +++++++++++++++++++
 tb/tb_iter_alu.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/iter_alu_if.sv
// Request/response bundle for iter_alu: operand handshake in, result handshake out.
interface iter_alu_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       ctr;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] hi;
  logic             zero;
  logic             busy;

  modport master (
    output in_valid, ctr, a, b, out_ready,
    input  in_ready, out_valid, result, hi, zero, busy
  );

  modport slave (
    input  in_valid, ctr, a, b, out_ready,
    output in_ready, out_valid, result, hi, zero, busy
  );
endinterface

// File: rtl/iter_alu.sv
// Handshaked MIPS-style ALU with iterative unsigned multiply/divide (HI/LO result).
// Optional signed MULT/DIV (ops 10/11) enabled by defining ITER_ALU_SIGNED_MULDIV_EN.
module iter_alu #(
  parameter int WIDTH = 32
) (
  input logic        clk,
  input logic        rst_n,
  iter_alu_if.slave  bus
);
  localparam int CNT_W = $clog2(WIDTH) + 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [WIDTH-1:0] ONE   = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ZEROW = {WIDTH{1'b0}};

  logic [1:0]       state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [WIDTH-1:0] hi_acc_r, lo_acc_r, opnd_r;
  logic [WIDTH-1:0] result_r, hi_r;
  logic             zero_r;
  logic             is_div_r;

  logic             accept_s;
  logic             iter_op_s, div_op_s;
  logic [WIDTH-1:0] a_mag_s, b_mag_s;
  logic [WIDTH-1:0] single_s;
  logic [WIDTH:0]   mul_sum_s, div_shift_s;
  logic             div_ge_s;
  logic [WIDTH-1:0] iter_hi_s, iter_lo_s;
  logic [WIDTH-1:0] fin_hi_s, fin_lo_s;

`ifdef ITER_ALU_SIGNED_MULDIV_EN
  logic neg_q_r, neg_r_r;
  logic neg_q_s, neg_r_s;

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x);
    return (~x) + ONE;
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] x);
    return (~x) + {{(2*WIDTH-1){1'b0}}, 1'b1};
  endfunction
`endif

  function automatic logic [WIDTH-1:0] single_op(input logic [3:0] op,
                                                 input logic [WIDTH-1:0] x,
                                                 input logic [WIDTH-1:0] y);
    logic [WIDTH-1:0] r;
    case (op)
      4'd0:    r = x & y;
      4'd1:    r = x | y;
      4'd2:    r = x + y;
      4'd3:    r = (x == y) ? ONE : ZEROW;
      4'd4:    r = (x <= y) ? ONE : ZEROW;
      4'd5:    r = (x >= y) ? ONE : ZEROW;
      4'd6:    r = x - y;
      4'd7:    r = (x < y) ? ONE : ZEROW;
      4'd12:   r = ~(x | y);
      default: r = ZEROW;
    endcase
    return r;
  endfunction

  assign accept_s = bus.in_valid && (state_r == IDLE);
  assign single_s = single_op(bus.ctr, bus.a, bus.b);

  // Classify the incoming op and derive the magnitudes loaded into the iterative core.
  always_comb begin
    a_mag_s   = bus.a;
    b_mag_s   = bus.b;
    iter_op_s = (bus.ctr == 4'd8) || (bus.ctr == 4'd9);
    div_op_s  = (bus.ctr == 4'd9);
`ifdef ITER_ALU_SIGNED_MULDIV_EN
    neg_q_s   = 1'b0;
    neg_r_s   = 1'b0;
    if ((bus.ctr == 4'd10) || (bus.ctr == 4'd11)) begin
      iter_op_s = 1'b1;
      div_op_s  = (bus.ctr == 4'd11);
      a_mag_s   = bus.a[WIDTH-1] ? neg_w(bus.a) : bus.a;
      b_mag_s   = bus.b[WIDTH-1] ? neg_w(bus.b) : bus.b;
      // Divide-by-zero keeps the all-ones quotient; negating the remainder restores a.
      neg_q_s   = (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]) && !((bus.ctr == 4'd11) && (bus.b == ZEROW));
      neg_r_s   = (bus.ctr == 4'd11) && bus.a[WIDTH-1];
    end else begin
      neg_q_s   = 1'b0;
      neg_r_s   = 1'b0;
    end
`endif
  end

  // One shift-add multiply step or one restoring-divide step on the HI/LO accumulators.
  always_comb begin
    mul_sum_s   = {1'b0, hi_acc_r} + (lo_acc_r[0] ? {1'b0, opnd_r} : {1'b0, ZEROW});
    div_shift_s = {hi_acc_r, lo_acc_r[WIDTH-1]};
    div_ge_s    = (div_shift_s >= {1'b0, opnd_r});
    if (is_div_r) begin
      if (div_ge_s) begin
        iter_hi_s = WIDTH'(div_shift_s - {1'b0, opnd_r});
        iter_lo_s = {lo_acc_r[WIDTH-2:0], 1'b1};
      end else begin
        iter_hi_s = div_shift_s[WIDTH-1:0];
        iter_lo_s = {lo_acc_r[WIDTH-2:0], 1'b0};
      end
    end else begin
      iter_hi_s = mul_sum_s[WIDTH:1];
      iter_lo_s = {mul_sum_s[0], lo_acc_r[WIDTH-1:1]};
    end
  end

  // Final-cycle result: sign fixup for signed ops, pass-through otherwise.
  always_comb begin
    fin_hi_s = iter_hi_s;
    fin_lo_s = iter_lo_s;
`ifdef ITER_ALU_SIGNED_MULDIV_EN
    if (is_div_r) begin
      if (neg_q_r) fin_lo_s = neg_w(iter_lo_s);
      else         fin_lo_s = iter_lo_s;
      if (neg_r_r) fin_hi_s = neg_w(iter_hi_s);
      else         fin_hi_s = iter_hi_s;
    end else if (neg_q_r) begin
      {fin_hi_s, fin_lo_s} = neg_2w({iter_hi_s, iter_lo_s});
    end else begin
      fin_hi_s = iter_hi_s;
      fin_lo_s = iter_lo_s;
    end
`endif
  end

  // Control FSM, operand capture, iteration and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      cnt_r    <= {CNT_W{1'b0}};
      hi_acc_r <= ZEROW;
      lo_acc_r <= ZEROW;
      opnd_r   <= ZEROW;
      result_r <= ZEROW;
      hi_r     <= ZEROW;
      zero_r   <= 1'b1;
      is_div_r <= 1'b0;
`ifdef ITER_ALU_SIGNED_MULDIV_EN
      neg_q_r  <= 1'b0;
      neg_r_r  <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            if (iter_op_s) begin
              state_r  <= CALC;
              cnt_r    <= CNT_W'(WIDTH);
              hi_acc_r <= ZEROW;
              lo_acc_r <= div_op_s ? a_mag_s : b_mag_s;
              opnd_r   <= div_op_s ? b_mag_s : a_mag_s;
              is_div_r <= div_op_s;
`ifdef ITER_ALU_SIGNED_MULDIV_EN
              neg_q_r  <= neg_q_s;
              neg_r_r  <= neg_r_s;
`endif
            end else begin
              state_r  <= DONE;
              result_r <= single_s;
              hi_r     <= ZEROW;
              zero_r   <= (single_s == ZEROW);
            end
          end
        end
        CALC: begin
          hi_acc_r <= iter_hi_s;
          lo_acc_r <= iter_lo_s;
          cnt_r    <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
          if (cnt_r == {{(CNT_W-1){1'b0}}, 1'b1}) begin
            state_r  <= DONE;
            result_r <= fin_lo_s;
            hi_r     <= fin_hi_s;
            zero_r   <= (fin_lo_s == ZEROW);
          end
        end
        DONE: begin
          if (bus.out_ready) state_r <= IDLE;
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state_r == IDLE);
  assign bus.out_valid = (state_r == DONE);
  assign bus.busy      = (state_r == CALC);
  assign bus.result    = result_r;
  assign bus.hi        = hi_r;
  assign bus.zero      = zero_r;
endmodule

// File: tb/tb_iter_alu.sv
// Scoreboard bench for iter_alu: directed corner cases plus random ops vs. an arithmetic model.
module tb_iter_alu;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  typedef struct {
    logic [W-1:0] res;
    logic [W-1:0] hi;
    int           lat;
    int           acc;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  bit   seen = 1'b0;

  iter_alu_if #(.WIDTH(W)) bus();
  iter_alu #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit is_iter(input logic [3:0] op);
`ifdef ITER_ALU_SIGNED_MULDIV_EN
    return (op == 4'd8) || (op == 4'd9) || (op == 4'd10) || (op == 4'd11);
`else
    return (op == 4'd8) || (op == 4'd9);
`endif
  endfunction

  // Reference behaviour computed straight from the op definitions.
  task automatic model(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                       output logic [W-1:0] r, output logic [W-1:0] h);
    logic [63:0] p;
    longint sp;
    int sx, sy;
    sx = x; sy = y;
    h = 32'd0;
    case (op)
      4'd0:  r = x & y;
      4'd1:  r = x | y;
      4'd2:  r = x + y;
      4'd3:  r = (x == y) ? 32'd1 : 32'd0;
      4'd4:  r = (x <= y) ? 32'd1 : 32'd0;
      4'd5:  r = (x >= y) ? 32'd1 : 32'd0;
      4'd6:  r = x - y;
      4'd7:  r = (x < y) ? 32'd1 : 32'd0;
      4'd8:  begin p = {32'd0, x} * {32'd0, y}; r = p[31:0]; h = p[63:32]; end
      4'd9:  begin
        if (y == 32'd0) begin r = 32'hFFFFFFFF; h = x; end
        else begin r = x / y; h = x % y; end
      end
      4'd12: r = ~(x | y);
`ifdef ITER_ALU_SIGNED_MULDIV_EN
      4'd10: begin sp = longint'(sx) * longint'(sy); p = sp; r = p[31:0]; h = p[63:32]; end
      4'd11: begin
        if (y == 32'd0) begin r = 32'hFFFFFFFF; h = x; end
        else if (x == 32'h80000000 && y == 32'hFFFFFFFF) begin r = x; h = 32'd0; end
        else begin r = sx / sy; h = sx % sy; end
      end
`endif
      default: r = 32'd0;
    endcase
  endtask

  // Called at posedge+1; offers one op and records the expected response once accepted.
  task automatic issue(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    int g = 0;
    while (!bus.in_ready && g < 200) begin @(posedge clk); #1; g++; end
    if (!bus.in_ready) chk("in_ready_timeout", 64'(bus.in_ready), 64'd1);
    bus.in_valid = 1'b1; bus.ctr = op; bus.a = x; bus.b = y;
    @(posedge clk);
    #1;
    model(op, x, y, e.res, e.hi);
    e.lat = is_iter(op) ? W + 1 : 1;
    e.acc = cyc;
    exp_q.push_back(e);
    bus.in_valid = 1'b0;
    bus.ctr = 4'($urandom); bus.a = $urandom; bus.b = $urandom;
  endtask

  task automatic drain(input bit rand_ready);
    int g = 0;
    while (exp_q.size() != 0 && g < 500) begin
      bus.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk); #1; g++;
    end
    if (exp_q.size() != 0) chk("drain_timeout", 64'(exp_q.size()), 64'd0);
    bus.out_ready = 1'b1;
  endtask

  // Monitor: compare each presented result against the scoreboard head.
  always @(negedge clk) begin
    if (!rst_n) begin
      seen = 1'b0;
    end else if (bus.out_valid) begin
      if (!seen) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out_valid", 64'd1, 64'd0);
        end else begin
          cur = exp_q[0];
          chk("result", 64'(bus.result), 64'(cur.res));
          chk("hi", 64'(bus.hi), 64'(cur.hi));
          chk("zero", 64'(bus.zero), 64'(cur.res == 32'd0));
          chk("latency", 64'(cyc - cur.acc + 1), 64'(cur.lat));
          seen = 1'b1;
        end
      end else begin
        chk("hold_result", 64'(bus.result), 64'(cur.res));
        chk("hold_hi", 64'(bus.hi), 64'(cur.hi));
      end
      if (bus.out_ready && seen) begin
        void'(exp_q.pop_front());
        seen = 1'b0;
      end
    end
  end

  initial begin
    int busy_n;
    int stale;
    logic [3:0] op;
    logic [W-1:0] x, y;
    bus.in_valid = 1'b0; bus.ctr = 4'd0; bus.a = 32'd0; bus.b = 32'd0;
    bus.out_ready = 1'b1;

    // Reset state
    #12;
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_result", 64'(bus.result), 64'd0);
    chk("rst_hi", 64'(bus.hi), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_zero", 64'(bus.zero), 64'd1);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("in_ready_after_rst", 64'(bus.in_ready), 64'd1);

    // Single-cycle ops
    issue(4'd2, 32'hFFFFFFFF, 32'd1);
    issue(4'd3, 32'd5, 32'd5);
    issue(4'd4, 32'd6, 32'd5);
    issue(4'd12, 32'd0, 32'd0);
    drain(1'b0);

    // MULTU max*max with busy duration
    issue(4'd8, 32'hFFFFFFFF, 32'hFFFFFFFF);
    busy_n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.out_valid) break;
      if (bus.busy) busy_n++;
    end
    chk("multu_busy_cycles", 64'(busy_n), 64'd32);
    @(posedge clk); #1;
    drain(1'b0);

    // DIVU, including divide by zero
    issue(4'd9, 32'd100, 32'd7);
    issue(4'd9, 32'd5, 32'd0);
    drain(1'b0);

    // Backpressure on SUB with a competing request offered during the stall
    bus.out_ready = 1'b0;
    issue(4'd6, 32'd3, 32'd5);
    bus.in_valid = 1'b1; bus.ctr = 4'd2; bus.a = 32'd1; bus.b = 32'd1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
      chk("bp_out_valid", 64'(bus.out_valid), 64'd1);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_idle_after_hs", 64'(bus.in_ready), 64'd1);
    chk("bp_queue_empty", 64'(exp_q.size()), 64'd0);

    // Reset in the middle of a multiply
    issue(4'd8, 32'd7, 32'd9);
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("midrst_result", 64'(bus.result), 64'd0);
    chk("midrst_busy", 64'(bus.busy), 64'd0);
    exp_q.delete();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("midrst_in_ready", 64'(bus.in_ready), 64'd1);
    stale = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.out_valid) stale++;
    end
    chk("midrst_no_stale", 64'(stale), 64'd0);
    @(posedge clk); #1;

    // Signed ops, or unused-code behaviour of 10/11 without the option
    issue(4'd11, 32'hFFFFFFF9, 32'd2);
    issue(4'd10, 32'hFFFFFFFD, 32'd4);
    issue(4'd11, 32'h80000000, 32'hFFFFFFFF);
    issue(4'd11, 32'hFFFFFFF9, 32'd0);
    drain(1'b0);

    // Random ops with random backpressure
    for (int n = 0; n < 60; n++) begin
      op = 4'($urandom_range(0, 15));
      x = ($urandom_range(0, 4) == 0) ? 32'($urandom_range(0, 9)) : $urandom;
      y = ($urandom_range(0, 4) == 0) ? 32'($urandom_range(0, 9)) : $urandom;
      if ($urandom_range(0, 9) == 0) x = 32'h80000000;
      issue(op, x, y);
      drain(1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
